rf_write_arbiter: RTL and testbench

- Shares the single register-file write port (we_RF, A3, WD3) between NUM_REQ independent write requesters, e.g. ALU writeback, load unit and debug/config port.
- Uses round-robin arbitration with a valid/ready handshake per requester.
- Drives the register file through one registered output slot that honours a downstream stall.
- Rejects out-of-range register indices and counts committed writes.

---
 rtl/rf_pkg.sv | 17 +
 rtl/rf_write_arbiter_rr_grant.sv | 30 +++
 rtl/rf_write_arbiter.sv | 158 +++++++++++++++
 tb/tb_rf_write_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Register-file shared constants, types and arbiter state encoding.
package rf_pkg;

  localparam int unsigned NUM_REGS = 13;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned DATA_W   = 26;

  typedef logic [ADDR_W-1:0] rf_addr_t;
  typedef logic [DATA_W-1:0] rf_data_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rf_write_arbiter_rr_grant.sv
// Combinational round-robin picker: first set request at or after i_ptr, wrapping.
module rr_grant #(
  parameter int unsigned N  = 3,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  // Scan N positions starting at the pointer; the first hit wins.
  always_comb begin
    int unsigned j;
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    j     = 0;
    for (int unsigned i = 0; i < N; i++) begin
      j = (32'(i_ptr) + i) % N;
      if (!o_any && i_req[j]) begin
        o_gnt[j] = 1'b1;
        o_idx    = IW'(j);
        o_any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the single register-file write port between NUM_REQ requesters
// through one registered slot; drops out-of-range writes and counts commits.
module rf_write_arbiter #(
  parameter int unsigned NUM_REQ  = 3,
  parameter int unsigned NUM_REGS = rf_pkg::NUM_REGS,
  parameter int unsigned ADDR_W   = rf_pkg::ADDR_W,
  parameter int unsigned DATA_W   = rf_pkg::DATA_W,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic                        rf_stall,
  output logic                        we_RF,
  output logic [ADDR_W-1:0]           A3,
  output logic [DATA_W-1:0]           WD3,
  output logic                        err_addr,
  output logic [$clog2(NUM_REQ)-1:0]  err_id,
  input  logic                        err_clr,
  output logic [CNT_W-1:0]            wr_count
);

  import rf_pkg::*;

  localparam int unsigned IW = $clog2(NUM_REQ);

  arb_state_t          r_state;
  arb_state_t          w_next;
  logic [IW-1:0]       r_ptr;
  logic [NUM_REQ-1:0]  w_gnt;
  logic [IW-1:0]       w_idx;
  logic                w_any;
  logic                w_slot_free;
  logic                w_accept;
  logic                w_legal;
  logic                w_illegal;
  logic                w_commit;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_data;
  logic                r_we;
  logic [ADDR_W-1:0]   r_a3;
  logic [DATA_W-1:0]   r_wd3;
  logic                r_err;
  logic [IW-1:0]       r_err_id;
  logic [CNT_W-1:0]    r_cnt;

  rr_grant #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr_grant (
    .i_req (req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  // Slot can take a new write when empty or when its current write drains now.
  assign w_slot_free = rst & ((r_state == IDLE) | ~rf_stall);
  assign w_accept    = w_slot_free & w_any;
  assign w_legal     = w_accept & (32'(w_addr) < NUM_REGS);
  assign w_illegal   = w_accept & ~(32'(w_addr) < NUM_REGS);
  assign w_commit    = r_we & ~rf_stall;
  assign req_ready   = w_slot_free ? w_gnt : '0;

  // Route the granted requester's address and data.
  always_comb begin
    w_addr = '0;
    w_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_addr = req_addr[i*ADDR_W +: ADDR_W];
        w_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state logic for the output slot.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_legal) w_next = ISSUE;
      end
      ISSUE, HOLD: begin
        if (rf_stall)     w_next = HOLD;
        else if (w_legal) w_next = ISSUE;
        else              w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // State register with registered write enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_we    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_we    <= (w_next != IDLE);
    end
  end

  // Slot payload loads only on a legal accept and otherwise holds.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a3  <= '0;
      r_wd3 <= '0;
    end else if (w_legal) begin
      r_a3  <= w_addr;
      r_wd3 <= w_data;
    end
  end

  // Round-robin pointer moves past the winner on every accept, legal or not.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= '0;
    end else if (w_accept) begin
      r_ptr <= (w_idx == IW'(NUM_REQ - 1)) ? '0 : w_idx + IW'(1);
    end
  end

  // Sticky error keeps the first offender; a new error beats a clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err    <= 1'b0;
      r_err_id <= '0;
    end else if (w_illegal) begin
      r_err <= 1'b1;
      if (!r_err || err_clr) r_err_id <= w_idx;
    end else if (err_clr) begin
      r_err    <= 1'b0;
      r_err_id <= '0;
    end
  end

  // Saturating count of writes actually taken by the register file.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (w_commit && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign we_RF    = r_we;
  assign A3       = r_a3;
  assign WD3      = r_wd3;
  assign err_addr = r_err;
  assign err_id   = r_err_id;
  assign wr_count = r_cnt;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter against a transaction-level model.
module tb_rf_write_arbiter;

  localparam int unsigned NR    = 3;
  localparam int unsigned NREGS = 13;
  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 26;
  localparam int unsigned CW    = 4;
  localparam int          CMAX  = (1 << CW) - 1;

  logic              clk;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_ready;
  logic              rf_stall;
  logic              we_RF;
  logic [AW-1:0]     A3;
  logic [DW-1:0]     WD3;
  logic              err_addr;
  logic [1:0]        err_id;
  logic              err_clr;
  logic [CW-1:0]     wr_count;

  rf_write_arbiter #(
    .NUM_REQ  (NR),
    .NUM_REGS (NREGS),
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .CNT_W    (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rf_stall  (rf_stall),
    .we_RF     (we_RF),
    .A3        (A3),
    .WD3       (WD3),
    .err_addr  (err_addr),
    .err_id    (err_id),
    .err_clr   (err_clr),
    .wr_count  (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_fail;

  // Stimulus held per requester until accepted
  logic          drv_v [NR];
  logic [AW-1:0] drv_a [NR];
  logic [DW-1:0] drv_d [NR];
  logic          drv_stall;
  logic          drv_clr;

  // Reference model: one pending write slot, RR pointer, sticky error, counter
  bit            m_full;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  int            m_ptr;
  bit            m_err;
  int            m_eid;
  int            m_cnt;
  int            last_g;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_full = 0; m_addr = '0; m_data = '0; m_ptr = 0;
    m_err = 0; m_eid = 0; m_cnt = 0; last_g = -1;
  endtask

  task automatic apply();
    for (int i = 0; i < NR; i++) begin
      req_valid[i]           = drv_v[i];
      req_addr[i*AW +: AW]   = drv_a[i];
      req_data[i*DW +: DW]   = drv_d[i];
    end
    rf_stall = drv_stall;
    err_clr  = drv_clr;
  endtask

  // One clock: check grant mid-cycle, advance model, check outputs after edge.
  task automatic cycle();
    int            g;
    bit            free;
    bit            illegal;
    logic [NR-1:0] exp_rdy;
    apply();
    @(negedge clk);
    free = !m_full || !drv_stall;
    g = -1;
    if (free) begin
      for (int k = 0; k < NR; k++) begin
        int j;
        j = (m_ptr + k) % NR;
        if (g < 0 && drv_v[j]) g = j;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check_eq("req_ready", 32'(req_ready), 32'(exp_rdy));

    if (!(m_full && drv_stall)) begin
      if (m_full && m_cnt < CMAX) m_cnt++;
      m_full = 0;
    end
    illegal = (g >= 0) && (int'(drv_a[g]) >= NREGS);
    if (g >= 0) begin
      m_ptr = (g + 1) % NR;
      if (!illegal) begin
        m_full = 1; m_addr = drv_a[g]; m_data = drv_d[g];
      end
    end
    if (illegal) begin
      if (!m_err || drv_clr) m_eid = g;
      m_err = 1;
    end else if (drv_clr) begin
      m_err = 0; m_eid = 0;
    end
    last_g = g;

    @(posedge clk);
    #1;
    check_eq("we_RF", 32'(we_RF), 32'(m_full));
    if (m_full) begin
      check_eq("A3", 32'(A3), 32'(m_addr));
      check_eq("WD3", 32'(WD3), 32'(m_data));
    end
    check_eq("err_addr", 32'(err_addr), 32'(m_err));
    check_eq("err_id", 32'(err_id), 32'(m_eid));
    check_eq("wr_count", 32'(wr_count), 32'(m_cnt));
    if (g >= 0) drv_v[g] = 1'b0;
  endtask

  task automatic clear_drv();
    for (int i = 0; i < NR; i++) begin
      drv_v[i] = 1'b0; drv_a[i] = '0; drv_d[i] = '0;
    end
    drv_stall = 1'b0;
    drv_clr   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fair_exp [6];
    fair_exp = '{1, 2, 0, 1, 2, 0};
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b0;
    clear_drv();
    for (int i = 0; i < NR; i++) drv_v[i] = 1'b1;
    apply();
    model_reset();

    // Reset values, with every requester asserting valid
    #12;
    check_eq("rst_we", 32'(we_RF), 32'd0);
    check_eq("rst_A3", 32'(A3), 32'd0);
    check_eq("rst_WD3", 32'(WD3), 32'd0);
    check_eq("rst_ready", 32'(req_ready), 32'd0);
    check_eq("rst_err", 32'(err_addr), 32'd0);
    check_eq("rst_cnt", 32'(wr_count), 32'd0);
    clear_drv();
    apply();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Single write
    drv_v[0] = 1'b1; drv_a[0] = 5'd5; drv_d[0] = 26'h2AAAAAA;
    cycle();
    check_eq("single_gnt", 32'(last_g), 32'd0);
    check_eq("single_A3", 32'(A3), 32'd5);
    check_eq("single_WD3", 32'(WD3), 32'h2AAAAAA);
    cycle();
    check_eq("single_cnt", 32'(wr_count), 32'd1);

    // Fairness: all valid continuously, pointer now at 1
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < NR; i++) begin
        drv_v[i] = 1'b1; drv_a[i] = AW'(i + 1); drv_d[i] = DW'($urandom);
      end
      cycle();
      check_eq("fair_gnt", 32'(last_g), 32'(fair_exp[k]));
      check_eq("fair_we", 32'(we_RF), 32'd1);
    end
    clear_drv();
    cycle();
    check_eq("fair_cnt", 32'(wr_count), 32'd7);

    // Stall hold with a competing requester waiting
    drv_v[1] = 1'b1; drv_a[1] = 5'd7; drv_d[1] = DW'($urandom);
    cycle();
    check_eq("stall_gnt", 32'(last_g), 32'd1);
    drv_stall = 1'b1;
    drv_v[0] = 1'b1; drv_a[0] = 5'd3; drv_d[0] = DW'($urandom);
    for (int k = 0; k < 3; k++) begin
      cycle();
      check_eq("stall_A3", 32'(A3), 32'd7);
      check_eq("stall_ready", 32'(req_ready), 32'd0);
      check_eq("stall_cnt", 32'(wr_count), 32'd7);
    end
    drv_stall = 1'b0;
    cycle();
    check_eq("unstall_cnt", 32'(wr_count), 32'd8);
    check_eq("unstall_gnt", 32'(last_g), 32'd0);
    cycle();
    check_eq("drain_cnt", 32'(wr_count), 32'd9);

    // Illegal addresses: first offender is kept
    drv_v[2] = 1'b1; drv_a[2] = 5'd13; drv_d[2] = DW'($urandom);
    cycle();
    check_eq("ill1_gnt", 32'(last_g), 32'd2);
    check_eq("ill1_we", 32'(we_RF), 32'd0);
    drv_v[1] = 1'b1; drv_a[1] = 5'd20; drv_d[1] = DW'($urandom);
    cycle();
    check_eq("ill2_gnt", 32'(last_g), 32'd1);
    check_eq("ill_err", 32'(err_addr), 32'd1);
    check_eq("ill_id", 32'(err_id), 32'd2);
    drv_clr = 1'b1;
    cycle();
    drv_clr = 1'b0;
    check_eq("clr_err", 32'(err_addr), 32'd0);
    check_eq("clr_id", 32'(err_id), 32'd0);

    // Counter saturation
    for (int k = 0; k < 20; k++) begin
      drv_v[0] = 1'b1; drv_a[0] = AW'($urandom_range(0, 12)); drv_d[0] = DW'($urandom);
      cycle();
    end
    cycle();
    check_eq("sat_cnt", 32'(wr_count), 32'(CMAX));

    // Asynchronous reset while holding a stalled write
    drv_v[2] = 1'b1; drv_a[2] = 5'd4; drv_d[2] = DW'($urandom);
    cycle();
    drv_stall = 1'b1;
    cycle();
    check_eq("hold_we", 32'(we_RF), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check_eq("arst_we", 32'(we_RF), 32'd0);
    check_eq("arst_cnt", 32'(wr_count), 32'd0);
    model_reset();
    clear_drv();
    apply();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      drv_v[i] = 1'b1; drv_a[i] = AW'(i + 8); drv_d[i] = DW'($urandom);
    end
    cycle();
    check_eq("arst_gnt", 32'(last_g), 32'd0);

    // Randomised traffic with stalls, clears and occasional bad addresses
    for (int n = 0; n < 400; n++) begin
      drv_stall = ($urandom % 4) == 0;
      drv_clr   = ($urandom % 16) == 0;
      for (int i = 0; i < NR; i++) begin
        if (!drv_v[i] && ($urandom % 2) == 1) begin
          drv_v[i] = 1'b1;
          drv_a[i] = (($urandom % 8) == 0) ? AW'($urandom_range(13, 31))
                                           : AW'($urandom_range(0, 12));
          drv_d[i] = DW'($urandom);
        end
      end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
